// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: owns the PC, drives a variable-latency
// instruction-memory request/ready port and squashes wrong-path fetches on redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic        jumpD,
  input  logic [31:0] pcbranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic [5:0]  opD,
  output logic [5:0]  functD,
  output logic        validD,
  output logic [31:0] fetch_wait_cnt,
  output logic [1:0]  state_dbg
);

  // imem handshake: a transfer happens on any cycle with imem_req & imem_ready;
  // imem_req/imem_addr are held stable from request until that transfer.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    KILL  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc_f, pc_f_n;
  logic [31:0] pc_pending, pc_pending_n;
  logic [31:0] hold_instr, hold_instr_n;
  logic [31:0] hold_pcplus4, hold_pcplus4_n;
  logic [31:0] instr_n, pcplus4_n;
  logic        valid_n;
  logic        xfer, redirect;
  logic [31:0] target, pc_f_plus4;

  assign pc_f_plus4 = pc_f + 32'd4;
  assign xfer       = imem_req & imem_ready;
  assign redirect   = validD & ~stallD & (pcsrcD | jumpD);
  assign target     = pcsrcD ? pcbranchD : {pcplus4D[31:28], instrD[25:0], 2'b00};

  // In KILL, pc_f still holds the address of the abandoned request.
  assign imem_req  = ~reset & (state != HOLD);
  assign imem_addr = pc_f;
  assign opD       = instrD[31:26];
  assign functD    = instrD[5:0];
  assign state_dbg = state;

  always_comb begin
    state_n        = state;
    pc_f_n         = pc_f;
    pc_pending_n   = pc_pending;
    hold_instr_n   = hold_instr;
    hold_pcplus4_n = hold_pcplus4;
    instr_n        = instrD;
    pcplus4_n      = pcplus4D;
    valid_n        = validD;
    case (state)
      FETCH: begin
        if (xfer) begin
          if (redirect) begin
            pc_f_n    = target;
            instr_n   = 32'd0;
            pcplus4_n = 32'd0;
            valid_n   = 1'b0;
          end else if (stallD) begin
            hold_instr_n   = imem_rdata;
            hold_pcplus4_n = pc_f_plus4;
            pc_f_n         = pc_f_plus4;
            state_n        = HOLD;
          end else begin
            instr_n   = imem_rdata;
            pcplus4_n = pc_f_plus4;
            valid_n   = 1'b1;
            pc_f_n    = pc_f_plus4;
          end
        end else if (redirect) begin
          pc_pending_n = target;
          state_n      = KILL;
          instr_n      = 32'd0;
          pcplus4_n    = 32'd0;
          valid_n      = 1'b0;
        end else if (!stallD) begin
          instr_n   = 32'd0;
          pcplus4_n = 32'd0;
          valid_n   = 1'b0;
        end
      end
      KILL: begin
        if (xfer) begin
          pc_f_n  = pc_pending;
          state_n = FETCH;
        end
        if (!stallD) begin
          instr_n   = 32'd0;
          pcplus4_n = 32'd0;
          valid_n   = 1'b0;
        end
      end
      HOLD: begin
        if (!stallD) begin
          state_n = FETCH;
          if (redirect) begin
            pc_f_n    = target;
            instr_n   = 32'd0;
            pcplus4_n = 32'd0;
            valid_n   = 1'b0;
          end else begin
            instr_n   = hold_instr;
            pcplus4_n = hold_pcplus4;
            valid_n   = 1'b1;
          end
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FETCH;
      pc_f           <= RESET_PC;
      pc_pending     <= RESET_PC;
      hold_instr     <= 32'd0;
      hold_pcplus4   <= 32'd0;
      instrD         <= 32'd0;
      pcplus4D       <= 32'd0;
      validD         <= 1'b0;
      fetch_wait_cnt <= 32'd0;
    end else begin
      state        <= state_n;
      pc_f         <= pc_f_n;
      pc_pending   <= pc_pending_n;
      hold_instr   <= hold_instr_n;
      hold_pcplus4 <= hold_pcplus4_n;
      instrD       <= instr_n;
      pcplus4D     <= pcplus4_n;
      validD       <= valid_n;
      if (imem_req && !imem_ready) fetch_wait_cnt <= fetch_wait_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a bench-side memory with configurable wait
// states, hand-computed expected values and one checking task.
module tb_fetch_stage;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_KILL  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic        clk;
  logic        reset;
  logic        stallD, pcsrcD, jumpD;
  logic [31:0] pcbranchD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instrD, pcplus4D;
  logic [5:0]  opD, functD;
  logic        validD;
  logic [31:0] fetch_wait_cnt;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int wait_cfg = 0;
  int wait_left = 0;
  logic [31:0] exp_q[$];

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stallD(stallD), .pcsrcD(pcsrcD), .jumpD(jumpD),
    .pcbranchD(pcbranchD), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .instrD(instrD),
    .pcplus4D(pcplus4D), .opD(opD), .functD(functD), .validD(validD),
    .fetch_wait_cnt(fetch_wait_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1000_0004) return 32'h0800_0010;
    return (a >> 2) + 32'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive_mem();
    if (imem_req) begin
      imem_rdata = mem_word(imem_addr);
      imem_ready = (wait_left == 0);
    end else begin
      imem_rdata = 32'd0;
      imem_ready = 1'b0;
    end
  endtask

  task automatic settle();
    #1;
    drive_mem();
  endtask

  task automatic tick();
    logic pr, px;
    pr = imem_req;
    px = imem_req & imem_ready;
    @(posedge clk);
    #1;
    if (!pr || px) wait_left = wait_cfg;
    else if (wait_left > 0) wait_left--;
    drive_mem();
  endtask

  initial begin
    reset = 1'b1; stallD = 1'b0; pcsrcD = 1'b0; jumpD = 1'b0;
    pcbranchD = 32'd0; imem_ready = 1'b0; imem_rdata = 32'd0;
    tick();
    tick();
    chk("rst_state", state_dbg, S_FETCH);
    chk("rst_valid", validD, 0);
    chk("rst_instr", instrD, 0);
    chk("rst_pcplus4", pcplus4D, 0);
    chk("rst_waitcnt", fetch_wait_cnt, 0);
    chk("rst_req", imem_req, 0);
    reset = 1'b0;
    settle();
    chk("rel_req", imem_req, 1);

    // zero-wait streaming
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(i + 1);
      chk("t1_addr", imem_addr, 4 * i);
      tick();
      chk("t1_valid", validD, 1);
      chk("t1_instr", instrD, exp_q.pop_front());
      chk("t1_pcplus4", pcplus4D, 4 * i + 4);
    end
    chk("t1_waitcnt", fetch_wait_cnt, 0);

    // three wait states per access
    wait_cfg = 3;
    tick();
    chk("t2_instr5", instrD, 5);
    for (int n = 0; n < 2; n++) begin
      for (int b = 0; b < 3; b++) begin
        tick();
        chk("t2_bub_valid", validD, 0);
        chk("t2_bub_instr", instrD, 0);
      end
      if (n == 1) wait_cfg = 0;
      tick();
      chk("t2_instr", instrD, 6 + n);
      chk("t2_valid", validD, 1);
      chk("t2_waitcnt", fetch_wait_cnt, 3 * (n + 1));
    end

    // stall while a transfer lands
    chk("t3_instr7", instrD, 7);
    stallD = 1'b1;
    settle();
    tick();
    chk("t3_state_hold", state_dbg, S_HOLD);
    chk("t3_req_hold", imem_req, 0);
    chk("t3_instr_held", instrD, 7);
    chk("t3_pcplus4_held", pcplus4D, 28);
    chk("t3_valid_held", validD, 1);
    tick();
    chk("t3_state_hold2", state_dbg, S_HOLD);
    chk("t3_instr_held2", instrD, 7);
    stallD = 1'b0;
    settle();
    tick();
    chk("t3_buf_instr", instrD, 8);
    chk("t3_buf_pcplus4", pcplus4D, 32);
    chk("t3_state_fetch", state_dbg, S_FETCH);
    chk("t3_addr", imem_addr, 32);
    tick();
    chk("t3_next_instr", instrD, 9);
    chk("t3_next_pcplus4", pcplus4D, 36);

    // taken branch, zero wait
    pcsrcD = 1'b1; pcbranchD = 32'h0000_0040;
    settle();
    tick();
    chk("t4_bub_valid", validD, 0);
    chk("t4_bub_instr", instrD, 0);
    chk("t4_addr", imem_addr, 32'h40);
    pcsrcD = 1'b0;
    settle();
    tick();
    chk("t4_tgt_instr", instrD, 17);
    chk("t4_tgt_pcplus4", pcplus4D, 32'h44);
    chk("t4_tgt_valid", validD, 1);

    // jump while memory is busy
    pcsrcD = 1'b1; pcbranchD = 32'h1000_0004;
    settle();
    tick();
    chk("t5_addr_br", imem_addr, 32'h1000_0004);
    pcsrcD = 1'b0; wait_cfg = 4;
    settle();
    tick();
    chk("t5_j_instr", instrD, 32'h0800_0010);
    chk("t5_j_pcplus4", pcplus4D, 32'h1000_0008);
    chk("t5_opD", opD, 6'h02);
    chk("t5_functD", functD, 6'h10);
    jumpD = 1'b1;
    settle();
    tick();
    chk("t5_state_kill", state_dbg, S_KILL);
    chk("t5_kill_valid", validD, 0);
    chk("t5_kill_addr", imem_addr, 32'h1000_0008);
    jumpD = 1'b0;
    settle();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_kill_state", state_dbg, S_KILL);
      chk("t5_kill_addr_hold", imem_addr, 32'h1000_0008);
      chk("t5_kill_req", imem_req, 1);
      chk("t5_kill_bubble", validD, 0);
    end
    wait_cfg = 0;
    tick();
    chk("t5_back_fetch", state_dbg, S_FETCH);
    chk("t5_new_addr", imem_addr, 32'h1000_0040);
    chk("t5_stale_dropped", validD, 0);
    chk("t5_waitcnt", fetch_wait_cnt, 10);
    wait_cfg = 5;
    tick();
    chk("t5_tgt_instr", instrD, 32'h0400_0011);
    chk("t5_tgt_pcplus4", pcplus4D, 32'h1000_0044);
    chk("t5_tgt_valid", validD, 1);

    // reset mid-wait
    tick();
    chk("t6_waitcnt_pre", fetch_wait_cnt, 11);
    reset = 1'b1; wait_cfg = 0;
    settle();
    chk("t6_req_in_reset", imem_req, 0);
    tick();
    chk("t6_state", state_dbg, S_FETCH);
    chk("t6_valid", validD, 0);
    chk("t6_instr", instrD, 0);
    chk("t6_pcplus4", pcplus4D, 0);
    chk("t6_waitcnt", fetch_wait_cnt, 0);
    reset = 1'b0;
    settle();
    chk("t6_addr_reset_pc", imem_addr, 0);
    tick();
    chk("t6_first_instr", instrD, 1);
    chk("t6_first_valid", validD, 1);

    // PC+4 wrap at the top of the address space
    pcsrcD = 1'b1; pcbranchD = 32'hFFFF_FFFC;
    settle();
    tick();
    chk("t7_addr_top", imem_addr, 32'hFFFF_FFFC);
    pcsrcD = 1'b0;
    settle();
    tick();
    chk("t7_instr", instrD, 32'h4000_0000);
    chk("t7_pcplus4_wrap", pcplus4D, 0);
    chk("t7_addr_wrap", imem_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the pipelined MIPS core.
- Owns the PC and drives a variable-latency instruction-memory request/ready interface.
- Delivers instrD, opD, functD and pcplus4D to the decode-stage controller and datapath.
- Applies branch/jump redirects resolved in Decode, with no delay slot: the wrong-path instruction is squashed to a bubble.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
stallD  input  1  hazard unit: hold the IF/ID register and the PC
pcsrcD  input  1  branch taken in Decode
jumpD  input  1  jump in Decode
pcbranchD  input  32  branch target from Decode
imem_req  output  1  fetch request
imem_addr  output  32  fetch address (word aligned)
imem_rdata  input  32  instruction returned
imem_ready  input  1  response valid; a transfer occurs on a cycle with imem_req&imem_ready
instrD  output  32  decode-stage instruction (0 = nop bubble)
pcplus4D  output  32  PC+4 of instrD
opD  output  6  instrD[31:26]
functD  output  6  instrD[5:0]
validD  output  1  instrD is a real instruction
fetch_wait_cnt  output  32  cycles with imem_req=1 and imem_ready=0

Behaviour:
- Reset values (any cycle, including mid-transaction):
  - pcF=RESET_PC, state=FETCH.
  - instrD=0, pcplus4D=0, validD=0, fetch_wait_cnt=0.
  - Any outstanding request is abandoned; memory must tolerate this.
- imem_req=0 while reset=1. Otherwise imem_req=1 in FETCH and KILL, 0 in HOLD.
- imem_addr: pcF in FETCH; the latched old address in KILL. imem_addr and imem_req stay stable until the transfer completes.
- redirect = validD & ~stallD & (pcsrcD | jumpD).
  - Target = pcbranchD if pcsrcD (pcsrcD has priority); else {pcplus4D[31:28], instrD[25:0], 2'b00}.
- States and transitions:
  - FETCH, transfer this cycle:
    - redirect: discard data; pcF<=target; D<=bubble; stay FETCH.
    - stallD=1: hold D; latch imem_rdata and pcF+4 into hold buffer; pcF<=pcF+4; go HOLD.
    - otherwise: instrD<=imem_rdata; pcplus4D<=pcF+4; validD<=1; pcF<=pcF+4.
  - FETCH, no transfer:
    - redirect: save target in pc_pending; go KILL; D<=bubble.
    - stallD=1: hold D.
    - otherwise: D<=bubble.
  - KILL:
    - On transfer: discard data; pcF<=pc_pending; go FETCH.
    - D behaves as FETCH with no transfer (bubble unless stallD).
    - A further redirect in KILL is impossible, since D holds a bubble.
  - HOLD:
    - stallD=1: hold everything.
    - stallD=0: load the hold buffer into D with validD=1; go FETCH.
    - Redirect in HOLD (D still valid): drop the buffer; pcF<=target; D<=bubble; go FETCH.
- Bubble means instrD=0, pcplus4D=0, validD=0.
- stallD=1 freezes instrD/pcplus4D/validD exactly.
- Latency: zero-wait memory gives one instruction per cycle, and instrD appears the cycle after the transfer. A redirect costs exactly one bubble at zero wait, plus the remaining wait of any killed request.
- pcF+4 wraps modulo 2^32.
- fetch_wait_cnt increments when imem_req&~imem_ready and wraps at 2^32-1->0.
- opD/functD are purely combinational slices of instrD.

Test Plan:
- Reset, imem_ready tied 1, memory[i]=i+1 -> imem_addr 0,4,8,...; instrD 1,2,3,... one per cycle from the 2nd post-reset cycle; validD=1; fetch_wait_cnt stays 0.
- imem_ready 0 for 3 cycles per access -> three bubbles (validD=0, instrD=0) between valid instructions; fetch_wait_cnt increments by 3 per instruction.
- stallD=1 for 2 cycles while a transfer arrives -> instrD/pcplus4D unchanged; imem_req=0 in HOLD; the buffered instruction appears the cycle after stallD falls; no instruction lost or duplicated.
- beq in D with pcsrcD=1, pcbranchD=0x40, zero-wait memory -> next instrD is a bubble, then the instruction at 0x40; the instruction at pcplus4D is never validD.
- jumpD=1 with instrD=0x0800_0010, pcplus4D=0x1000_0008, memory busy 4 cycles -> state KILL; imem_addr holds the old address until ready; stale data discarded; next fetch address 0x1000_0040.
- reset asserted mid-wait (imem_ready=0) -> next cycle pcF=RESET_PC, validD=0, fetch_wait_cnt=0, state FETCH.
